// File: rtl/sign_adder_pkg.sv
// Shared definitions for the sign-magnitude adder arbiter: FSM states,
// default widths and the overflow helper used beside the shared adder.
package sign_adder_pkg;

   localparam int DEF_W    = 4;
   localparam int DEF_N    = 4;
   localparam int SM_MAX_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

   // Operands arrive zero-extended to SM_MAX_W; w is the real operand width.
   function automatic logic sm_ovf(input logic [SM_MAX_W-1:0] a,
                                   input logic [SM_MAX_W-1:0] b,
                                   input int                  w);
      logic [SM_MAX_W-1:0] mmask;
      logic [SM_MAX_W:0]   msum;
      mmask = (SM_MAX_W'(1) << (w - 1)) - SM_MAX_W'(1);
      msum  = {1'b0, a & mmask} + {1'b0, b & mmask};
      return (a[w-1] == b[w-1]) && (msum > {1'b0, mmask});
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin first-set search: returns the first valid requester at or
// after ptr, wrapping around, plus a found flag.
module rr_picker #(
   parameter int N   = 4,
   parameter int IDW = $clog2(N)
) (
   input  logic [N-1:0]   req_valid,
   input  logic [IDW-1:0] ptr,
   output logic [IDW-1:0] g,
   output logic           found
);

   always_comb begin
      g     = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!found && req_valid[(int'(ptr) + k) % N]) begin
            found = 1'b1;
            g     = IDW'((int'(ptr) + k) % N);
         end
      end
   end

endmodule

// File: rtl/sign_adder.sv
// Combinational sign-magnitude adder; MSB is the sign, the rest the magnitude.
// A zero magnitude is always returned with a positive sign.
module sign_adder #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum
);

   logic         sa, sb, sign;
   logic [W-2:0] ma, mb, mag;

   assign sa = a[W-1];
   assign sb = b[W-1];
   assign ma = a[W-2:0];
   assign mb = b[W-2:0];

   always_comb begin
      sign = sa;
      mag  = ma + mb;
      if (sa != sb) begin
         if (ma >= mb) begin
            mag  = ma - mb;
            sign = sa;
         end else begin
            mag  = mb - ma;
            sign = sb;
         end
      end
      if (mag == '0) begin
         sign = 1'b0;
      end
   end

   assign sum = {sign, mag};

endmodule

// File: rtl/sign_adder_arbiter.sv
// Shares one sign_adder between N requesters with round-robin arbitration;
// results return on a single registered, back-pressure-safe response port.
module sign_adder_arbiter
   import sign_adder_pkg::*;
#(
   parameter int N   = DEF_N,
   parameter int W   = DEF_W,
   parameter int IDW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req_valid,
   output logic [N-1:0]   req_ready,
   input  logic [N*W-1:0] req_a,
   input  logic [N*W-1:0] req_b,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic [IDW-1:0] rsp_id,
   output logic [W-1:0]   rsp_sum,
   output logic           rsp_ovf
);

   state_t         state;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] grant;
   logic           found;
   logic [IDW-1:0] lat_id;
   logic [IDW-1:0] next_ptr;
   logic [W-1:0]   lat_a;
   logic [W-1:0]   lat_b;
   logic [W-1:0]   add_sum;

   rr_picker #(
      .N   (N),
      .IDW (IDW)
   ) u_picker (
      .req_valid (req_valid),
      .ptr       (ptr),
      .g         (grant),
      .found     (found)
   );

   sign_adder #(
      .W (W)
   ) u_adder (
      .a   (lat_a),
      .b   (lat_b),
      .sum (add_sum)
   );

   // The only combinational output: a single grant strobe, only while idle.
   always_comb begin
      req_ready = '0;
      if (state == IDLE && found) begin
         req_ready[grant] = 1'b1;
      end
   end

   assign next_ptr = (lat_id == IDW'(N - 1)) ? '0 : lat_id + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         lat_id    <= '0;
         lat_a     <= '0;
         lat_b     <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_sum   <= '0;
         rsp_ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  lat_a  <= req_a[grant*W +: W];
                  lat_b  <= req_b[grant*W +: W];
                  lat_id <= grant;
                  state  <= CALC;
               end
            end
            CALC: begin
               rsp_sum   <= add_sum;
               rsp_ovf   <= sm_ovf(SM_MAX_W'(lat_a), SM_MAX_W'(lat_b), W);
               rsp_id    <= lat_id;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               // The pointer only advances once the result has been taken.
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  ptr       <= next_ptr;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sign_adder_arbiter.sv
// Directed self-checking bench for sign_adder_arbiter (N=4, W=4) with
// hand-computed sums, round-robin order, back-pressure and mid-op reset.
module tb_sign_adder_arbiter;

   localparam int N   = 4;
   localparam int W   = 4;
   localparam int IDW = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_a;
   logic [N*W-1:0] req_b;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [IDW-1:0] rsp_id;
   logic [W-1:0]   rsp_sum;
   logic           rsp_ovf;

   int total = 0;
   int bad   = 0;

   sign_adder_arbiter #(
      .N   (N),
      .W   (W),
      .IDW (IDW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_ovf   (rsp_ovf)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Called at a falling edge; waits (bounded) for a grant and reports its index.
   task automatic waitGrant(output int g);
      int n;
      n = 0;
      g = -1;
      #1;
      while (req_ready == '0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("grant_seen", 32'(req_ready != '0), 32'd1);
      checkOutput("grant_onehot", 32'($countones(req_ready)), 32'd1);
      for (int i = 0; i < N; i++) begin
         if (req_ready[i]) g = i;
      end
   endtask

   task automatic applyStimulus(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] sum_e, input logic ovf_e);
      int g;
      req_valid     = '0;
      req_valid[id] = 1'b1;
      req_a[id*W +: W] = a;
      req_b[id*W +: W] = b;
      rsp_ready     = 1'b1;
      waitGrant(g);
      checkOutput("grant_id", g, id);
      @(negedge clk);
      checkOutput("calc_valid", 32'(rsp_valid), 32'd0);
      // Other requesters and fresh operands must not disturb the latched op.
      req_valid = '1;
      req_a     = 16'($urandom);
      req_b     = 16'($urandom);
      #1;
      checkOutput("calc_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      checkOutput("resp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("resp_id", 32'(rsp_id), id);
      checkOutput("resp_sum", 32'(rsp_sum), 32'(sum_e));
      checkOutput("resp_ovf", 32'(rsp_ovf), 32'(ovf_e));
      checkOutput("resp_ready", 32'(req_ready), 32'd0);
      req_valid = '0;
      @(negedge clk);
      checkOutput("resp_drop", 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      int g;
      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rst_valid", 32'(rsp_valid), 32'd0);
      checkOutput("rst_id", 32'(rsp_id), 32'd0);
      checkOutput("rst_sum", 32'(rsp_sum), 32'd0);
      checkOutput("rst_ovf", 32'(rsp_ovf), 32'd0);
      checkOutput("rst_ready", 32'(req_ready), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] directed arithmetic vectors");
      applyStimulus(1, 4'b0011, 4'b1001, 4'b0010, 1'b0);
      applyStimulus(0, 4'b0101, 4'b0100, 4'b0001, 1'b1);
      applyStimulus(2, 4'b0011, 4'b1011, 4'b0000, 1'b0);
      applyStimulus(3, 4'b1110, 4'b1011, 4'b1001, 1'b1);
      applyStimulus(1, 4'b1010, 4'b0111, 4'b0101, 1'b0);
      applyStimulus(2, 4'b1111, 4'b0011, 4'b1100, 1'b0);
      applyStimulus(0, 4'b1100, 4'b1100, 4'b0000, 1'b1);
      applyStimulus(3, 4'b1000, 4'b0000, 4'b0000, 1'b0);

      $display("[TB] round-robin with all requesters active");
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < N; i++) begin
         req_a[i*W +: W] = W'(i);
         req_b[i*W +: W] = W'(1);
      end
      rsp_ready = 1'b1;
      req_valid = '1;
      for (int op = 0; op < 12; op++) begin
         waitGrant(g);
         checkOutput("rr_grant", g, op % N);
         @(negedge clk);
         @(negedge clk);
         checkOutput("rr_valid", 32'(rsp_valid), 32'd1);
         checkOutput("rr_id", 32'(rsp_id), op % N);
         checkOutput("rr_sum", 32'(rsp_sum), (op % N) + 1);
         @(negedge clk);
      end
      req_valid = '0;
      @(negedge clk);

      $display("[TB] back-pressure on the response port");
      req_valid    = 4'b1000;
      req_a[12 +: 4] = 4'b0001;
      req_b[12 +: 4] = 4'b0010;
      rsp_ready    = 1'b0;
      waitGrant(g);
      checkOutput("bp_grant", g, 3);
      @(negedge clk);
      @(negedge clk);
      checkOutput("bp_valid0", 32'(rsp_valid), 32'd1);
      req_valid = '1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checkOutput("bp_valid", 32'(rsp_valid), 32'd1);
         checkOutput("bp_id", 32'(rsp_id), 32'd3);
         checkOutput("bp_sum", 32'(rsp_sum), 32'b0011);
         checkOutput("bp_ovf", 32'(rsp_ovf), 32'd0);
         checkOutput("bp_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      checkOutput("bp_release", 32'(rsp_valid), 32'd0);
      checkOutput("bp_next_grant", 32'(req_ready), 32'b0001);
      req_valid = '0;
      @(negedge clk);

      $display("[TB] reset during an in-flight operation");
      applyStimulus(0, 4'b0001, 4'b0001, 4'b0010, 1'b0);
      req_valid = 4'b0010;
      req_a[4 +: 4] = 4'b0111;
      req_b[4 +: 4] = 4'b0001;
      waitGrant(g);
      checkOutput("mid_grant", g, 1);
      @(negedge clk);
      rst       = 1'b1;
      req_valid = '0;
      #1;
      checkOutput("mid_valid", 32'(rsp_valid), 32'd0);
      checkOutput("mid_id", 32'(rsp_id), 32'd0);
      checkOutput("mid_sum", 32'(rsp_sum), 32'd0);
      checkOutput("mid_ovf", 32'(rsp_ovf), 32'd0);
      checkOutput("mid_ready", 32'(req_ready), 32'd0);
      repeat (2) begin
         @(negedge clk);
         checkOutput("mid_hold", 32'(rsp_valid), 32'd0);
      end
      rst       = 1'b0;
      req_valid = 4'b0011;
      #1;
      checkOutput("mid_ptr", 32'(req_ready), 32'b0001);
      req_valid = '0;
      repeat (3) begin
         @(negedge clk);
         checkOutput("mid_no_rsp", 32'(rsp_valid), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
